ascii_bin_parser: RTL and testbench
===================================

# ascii_bin_parser

Converts a byte stream of ASCII binary text, one line per value, into WIDTH-bit numbers for the EZC1 datapath. It sits directly upstream of the input stage and replaces the simulation-only file read with synthesizable logic. Bytes arrive from the UART receiver over a valid/ready handshake. Each completed line is presented as one number with a valid/ready handshake.

## Interface
- WIDTH, 32, number width and maximum digit count per line
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_byte  input  8  ASCII character from upstream
- in_valid  input  1  in_byte valid
- in_ready  output  1  parser accepts in_byte this cycle
- number  output  WIDTH  parsed value, MSB-first, zero-extended
- number_valid  output  1  number holds a completed value
- number_ready  input  1  downstream consumes number
- err  output  1  one-cycle pulse on malformed line

## Operation
- A byte is accepted on a rising clk edge with in_valid && in_ready.
- States:
  - IDLE: no digits yet.
  - ACCUM: ≥1 digit held.
  - HOLD: number presented.
  - SKIP: discarding the rest of a bad line.
- Character classes: '0' (0x30), '1' (0x31), LF (0x0A), CR (0x0D), other.
- Digit in IDLE/ACCUM:
  - acc <= {acc[WIDTH-2:0], bit}; cnt++; go to ACCUM.
  - When cnt == WIDTH already (overflow): err pulse, clear acc/cnt, go to SKIP.
- LF:
  - In ACCUM: number <= acc, go to HOLD.
  - In IDLE: ignored (blank line), no output, no err.
  - In SKIP: go to IDLE.
- CR: ignored in every accepting state.
- Other character in IDLE/ACCUM: err pulse, clear acc/cnt, go to SKIP. In SKIP, all non-LF bytes are discarded silently.
- HOLD:
  - in_ready = 0; number_valid = 1; number is stable.
  - On number_ready: go to IDLE, clear acc/cnt.
- in_ready = (state != HOLD), combinational from state only.
- Width rule: fewer than WIDTH digits are right-aligned. For example, "101" gives 32'd5. Exactly WIDTH digits are legal.
- Reset values: state IDLE, acc 0, cnt 0, number 0, number_valid 0, err 0. in_ready is therefore 1 during and after reset.
- Reset asserted mid-line or in HOLD discards all partial and presented data immediately, with no err.

## Timing
- The LF is accepted at edge N. number_valid rises after edge N and is visible in cycle N+1.
- number_ready high in cycle N+1 means the value is consumed at edge N+1, and in_ready is high in cycle N+2.
- Minimum line period: digits + LF + 1 handshake cycle.
- err is registered: high for exactly the one cycle after the offending byte's accept edge.
- number_ready while number_valid is low has no effect.
- A new byte is never accepted in the same cycle that number_ready completes HOLD.

## Configuration
- ASCII_BIN_PARSER_COMMENT_EN defined:
  - '#' (0x23) in IDLE enters SKIP without err.
  - '#' in ACCUM finalises the digits seen so far as if LF, goes to HOLD, then discards bytes up to and including the next LF via SKIP after the handshake. A comment-pending flag selects the post-HOLD state.
- Not defined: '#' is an ordinary illegal character (err, SKIP).

## Structure
- Shared package ezc1_pkg holds:
  - ASCII constants: ASC_0, ASC_1, ASC_LF, ASC_CR, ASC_HASH.
  - The parser state enum: IDLE, ACCUM, HOLD, SKIP.
  - The character-class enum: CLS_DIGIT, CLS_LF, CLS_CR, CLS_HASH, CLS_OTHER.
- One sub-module, ascii_char_classify: purely combinational; maps in_byte to a class and a digit bit. The parser FSM stays in ascii_bin_parser.

## Test plan
- Stream "101\n", number_ready held 1 → number = 32'd5, number_valid high for exactly 1 cycle, err never asserted.
- Stream 32 '1's then "\r\n" → number = 32'hFFFF_FFFF. Then 33 '1's + "\n" → err pulse on the 33rd digit, no number_valid, and the next "10\n" yields 32'd2.
- Stream "1x0\n11\n" → err one cycle after 'x' accepted, single output 32'd3.
- "110\n" with number_ready held 0 for 5 cycles → in_ready 0 and number = 32'd6 stable throughout; bytes offered are not consumed until the cycle after number_ready.
- Assert rst_n low after "1011" is accepted, release, stream "1\n" → number = 32'd1; all outputs at reset values while rst_n low.
- With ASCII_BIN_PARSER_COMMENT_EN defined: "#abc\n11#zz\n" → single output 32'd3, no err. Without it, the same stream gives an err pulse on the first '#' and another on the second '#', and no output.

Source files
------------

// File: rtl/ezc1_pkg.sv
// Shared EZC1 front-end definitions: ASCII code points, the parser state
// encoding and the character classes used by the ASCII binary parser.
package ezc1_pkg;

  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_1    = 8'h31;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_HASH = 8'h23;

  typedef enum logic [1:0] {
    IDLE,   // no digits yet
    ACCUM,  // at least one digit held
    HOLD,   // number presented downstream
    SKIP    // discarding the remainder of a line
  } parser_state_e;

  typedef enum logic [2:0] {
    CLS_DIGIT,
    CLS_LF,
    CLS_CR,
    CLS_HASH,
    CLS_OTHER
  } char_cls_e;

endpackage

// File: rtl/ascii_bin_parser_if.sv
// Byte-in / number-out bus of the ASCII binary parser.
//   slave  : the parser (consumes bytes, produces numbers and err)
//   master : upstream byte source plus downstream number sink
interface ascii_bin_parser_if #(
  parameter int WIDTH = 32
) ();
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] number;
  logic             number_valid;
  logic             number_ready;
  logic             err;

  modport slave (
    input  in_byte, in_valid, number_ready,
    output in_ready, number, number_valid, err
  );

  modport master (
    output in_byte, in_valid, number_ready,
    input  in_ready, number, number_valid, err
  );
endinterface

// File: rtl/ascii_char_classify.sv
// Combinational character classifier.
//   ch_i   : ASCII byte
//   cls_o  : character class
//   bit_o  : digit value, meaningful only when cls_o == CLS_DIGIT
module ascii_char_classify
  import ezc1_pkg::*;
(
  input  logic [7:0] ch_i,
  output char_cls_e  cls_o,
  output logic       bit_o
);

  always_comb begin
    cls_o = CLS_OTHER;
    bit_o = (ch_i == ASC_1);
    case (ch_i)
      ASC_0, ASC_1: cls_o = CLS_DIGIT;
      ASC_LF:       cls_o = CLS_LF;
      ASC_CR:       cls_o = CLS_CR;
      ASC_HASH:     cls_o = CLS_HASH;
      default:      cls_o = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/ascii_bin_parser.sv
// ASCII binary text to WIDTH-bit number converter, one value per line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ascii_bin_parser_if.slave
//                in_byte/in_valid/in_ready       byte stream from the UART
//                number/number_valid/number_ready parsed value handshake
//                err                              one-cycle malformed-line pulse
// Build option: ASCII_BIN_PARSER_COMMENT_EN enables '#' line comments.
module ascii_bin_parser
  import ezc1_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ascii_bin_parser_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  parser_state_e    state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             err_q, err_d;
`ifdef ASCII_BIN_PARSER_COMMENT_EN
  // Set when a '#' closed the line early: the comment tail still has to
  // be discarded once the number has been handed off.
  logic             cmt_q, cmt_d;
`endif

  char_cls_e cls;
  logic      dig;
  logic      accept;

  ascii_char_classify u_cls (
    .ch_i  (bus.in_byte),
    .cls_o (cls),
    .bit_o (dig)
  );

  assign bus.in_ready     = (state_q != HOLD);
  assign bus.number_valid = (state_q == HOLD);
  assign bus.number       = num_q;
  assign bus.err          = err_q;
  assign accept           = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    err_d   = 1'b0;
`ifdef ASCII_BIN_PARSER_COMMENT_EN
    cmt_d   = cmt_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          case (cls)
            CLS_DIGIT: begin
              if (cnt_q == CW'(WIDTH)) begin
                // one digit too many: the whole line is rejected
                err_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = SKIP;
              end else begin
                acc_d   = {acc_q[WIDTH-2:0], dig};
                cnt_d   = cnt_q + 1'b1;
                state_d = ACCUM;
              end
            end
            CLS_LF: begin
              // blank lines in IDLE produce nothing
              if (state_q == ACCUM) begin
                num_d   = acc_q;
                state_d = HOLD;
              end
            end
            CLS_CR: ;
`ifdef ASCII_BIN_PARSER_COMMENT_EN
            CLS_HASH: begin
              if (state_q == ACCUM) begin
                num_d   = acc_q;
                cmt_d   = 1'b1;
                state_d = HOLD;
              end else begin
                state_d = SKIP;
              end
            end
`endif
            default: begin
              err_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = SKIP;
            end
          endcase
        end
      end
      HOLD: begin
        if (bus.number_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
`ifdef ASCII_BIN_PARSER_COMMENT_EN
          cmt_d   = 1'b0;
          state_d = cmt_q ? SKIP : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      SKIP: begin
        if (accept && cls == CLS_LF) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
`ifdef ASCII_BIN_PARSER_COMMENT_EN
      cmt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
`ifdef ASCII_BIN_PARSER_COMMENT_EN
      cmt_q   <= cmt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ascii_bin_parser.sv
module tb_ascii_bin_parser;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascii_bin_parser_if #(.WIDTH(WIDTH)) bus ();

  ascii_bin_parser #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int failed = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A line is just a digit count and a value; a finished line becomes an
  // entry in the expected-output queue; a bad line sets a skip flag.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_val;
  int               m_n;
  bit               m_skip;
  bit               err_exp;
  logic [WIDTH-1:0] out_log[$];
  int               err_seen;
  int               nv_cycles;

  task automatic m_clear_line();
    m_val = '0;
    m_n   = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip) begin
      if (b == 8'h0A) m_skip = 0;
    end else if (b == 8'h30 || b == 8'h31) begin
      if (m_n == WIDTH) begin
        err_exp = 1; m_skip = 1; m_clear_line();
      end else begin
        m_val = m_val * 2 + ((b == 8'h31) ? 1 : 0);
        m_n++;
      end
    end else if (b == 8'h0A) begin
      if (m_n > 0) m_q.push_back(m_val);
      m_clear_line();
    end else if (b == 8'h0D) begin
    end
`ifdef ASCII_BIN_PARSER_COMMENT_EN
    else if (b == 8'h23) begin
      if (m_n > 0) m_q.push_back(m_val);
      m_skip = 1; m_clear_line();
    end
`endif
    else begin
      err_exp = 1; m_skip = 1; m_clear_line();
    end
  endtask

  // Compare process: outputs are sampled mid-cycle, then the model is
  // advanced by whatever handshake will complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete(); m_skip = 0; err_exp = 0; m_clear_line();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_number_valid", bus.number_valid, 0);
      check("rst_err", bus.err, 0);
      check("rst_number", bus.number, 0);
    end else begin
      check("err", bus.err, err_exp);
      check("number_valid", bus.number_valid, m_q.size() != 0);
      check("in_ready", bus.in_ready, m_q.size() == 0);
      if (m_q.size() != 0) check("number", bus.number, m_q[0]);
      if (bus.err) err_seen++;
      if (bus.number_valid) nv_cycles++;
      err_exp = 0;
      if (m_q.size() != 0) begin
        if (bus.number_ready) begin
          out_log.push_back(m_q[0]);
          m_q.pop_front();
        end
      end else if (bus.in_valid) begin
        model_byte(bus.in_byte);
      end
    end
  end

  // ---------------- drivers ----------------
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled
  bit gaps = 0;

  initial begin
    bus.number_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.number_ready = 1'b1;
        1:       bus.number_ready = 1'($urandom_range(0, 1));
        default: bus.number_ready = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      failed++; tests++;
      $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b);
  endtask

  task automatic drain();
    int n = 0;
    while (m_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (m_q.size() != 0) begin
      failed++; tests++;
      $display("FAIL drain_timeout: %0d numbers still pending", m_q.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic start_case();
    out_log.delete(); err_seen = 0; nv_cycles = 0;
  endtask

  task automatic check_out(input string nm, input int cnt, input logic [WIDTH-1:0] v0,
                           input logic [WIDTH-1:0] v1, input int errs);
    check({nm, "_count"}, out_log.size(), cnt);
    if (cnt > 0 && out_log.size() > 0) check({nm, "_v0"}, out_log[0], v0);
    if (cnt > 1 && out_log.size() > 1) check({nm, "_v1"}, out_log[1], v1);
    check({nm, "_errs"}, err_seen, errs);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    start_case();
    send_str("101\n"); drain();
    check_out("t101", 1, 32'd5, 0, 0);
    check("t101_valid_cycles", nv_cycles, 1);

    start_case();
    send_rep("1", 32); send_str("\r\n");
    send_rep("1", 33); send_str("\n10\n"); drain();
    check_out("twidth", 2, 32'hFFFF_FFFF, 32'd2, 1);

    start_case();
    send_str("1x0\n11\n"); drain();
    check_out("tbad", 1, 32'd3, 0, 0 + 1);

    start_case();
    rdy_mode = 2;
    send_str("110\n");
    bus.in_byte = "1"; bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_number", bus.number, 32'd6);
    end
    rdy_mode = 0;
    send_byte("1"); send_str("\n"); drain();
    check_out("thold", 2, 32'd6, 32'd1, 0);

    start_case();
    send_str("1011");
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_number_valid", bus.number_valid, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_str("1\n"); drain();
    check_out("trst", 1, 32'd1, 0, 0);

    start_case();
    send_str("#abc\n11#zz\n"); drain();
`ifdef ASCII_BIN_PARSER_COMMENT_EN
    check_out("tcmt", 1, 32'd3, 0, 0);
`else
    check_out("tcmt", 0, 0, 0, 2);
`endif

    // randomized lines against the model
    rdy_mode = 1; gaps = 1;
    for (int l = 0; l < 300; l++) begin
      int kind = $urandom_range(0, 9);
      int len  = (kind == 0) ? $urandom_range(30, 34) : $urandom_range(0, 8);
      for (int k = 0; k < len; k++) begin
        int r = $urandom_range(0, 39);
        if (r == 0)      send_byte("x");
        else if (r == 1) send_byte(8'h0D);
        else if (r == 2) send_byte("#");
        else             send_byte((r % 2) ? "1" : "0");
      end
      if ($urandom_range(0, 4) == 0) send_byte(8'h0D);
      send_byte(8'h0A);
    end
    rdy_mode = 0; gaps = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
